sram_ana_initiator: RTL and testbench

SRAM_ANA_INITIATOR -- requirements
Module: sram_ana_initiator

---
 rtl/sram_ana_pkg.sv | 25 ++
 rtl/sram_ana_level_dec.sv | 24 ++
 rtl/sram_ana_initiator.sv | 121 ++++++++++++
 tb/tb_sram_ana_initiator.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ana_pkg.sv
// rtl/sram_ana_pkg.sv - shared defaults, level type and FSM encoding for the analog-coded SRAM initiator
// Contents: DEF_* parameter defaults, level_t (one analog-coded level), state_t (initiator FSM)
package sram_ana_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_ANA_WIDTH  = 8;
  localparam int DEF_FULL_SCALE = 255;
  localparam int DEF_THRESHOLD  = 128;

  typedef logic [DEF_ANA_WIDTH-1:0] level_t;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_SETUP   = S_SETUP,
    ST_STROBE  = S_STROBE,
    ST_CAPTURE = S_CAPTURE
  } state_t;

endpackage

// File: rtl/sram_ana_level_dec.sv
// rtl/sram_ana_level_dec.sv - per-lane threshold decode of analog-coded SRAM read data
// Ports: dout_a  in  DATA_WIDTH lanes of ANA_WIDTH-bit levels
//        bits    out decoded word, bit i = (dout_a[i] >= THRESHOLD), unsigned compare
module sram_ana_level_dec
  import sram_ana_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ANA_WIDTH  = DEF_ANA_WIDTH,
  parameter int THRESHOLD  = DEF_THRESHOLD
) (
  input  logic [ANA_WIDTH-1:0]  dout_a [DATA_WIDTH],
  output logic [DATA_WIDTH-1:0] bits
);

  localparam logic [ANA_WIDTH-1:0] THR_LV = ANA_WIDTH'(THRESHOLD);

  always_comb begin
    bits = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      bits[i] = (dout_a[i] >= THR_LV);
    end
  end

endmodule

// File: rtl/sram_ana_initiator.sv
// rtl/sram_ana_initiator.sv - request/response initiator driving an SRAM through analog-coded levels
// Ports: clk, rst (async, active high)
//        req_valid/req_ready/req_we/req_addr/req_wdata  request handshake
//        rsp_valid/rsp_data                             one-cycle response, data held between responses
//        clk_a/we_a/addr_a/din_a                        analog-coded SRAM drive (0 or FULL_SCALE)
//        dout_a                                         analog-coded SRAM read data
// Option: SRAM_INIT_READBACK_EN - writes also respond with the pre-write word
module sram_ana_initiator
  import sram_ana_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ANA_WIDTH  = DEF_ANA_WIDTH,
  parameter int FULL_SCALE = DEF_FULL_SCALE,
  parameter int THRESHOLD  = DEF_THRESHOLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ANA_WIDTH-1:0]  clk_a,
  output logic [ANA_WIDTH-1:0]  we_a,
  output logic [ANA_WIDTH-1:0]  addr_a [ADDR_WIDTH],
  output logic [ANA_WIDTH-1:0]  din_a  [DATA_WIDTH],
  input  logic [ANA_WIDTH-1:0]  dout_a [DATA_WIDTH]
);

  localparam logic [ANA_WIDTH-1:0] FS_LV = ANA_WIDTH'(FULL_SCALE);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_WIDTH-1:0] dec_bits;

  sram_ana_level_dec #(
    .DATA_WIDTH(DATA_WIDTH),
    .ANA_WIDTH (ANA_WIDTH),
    .THRESHOLD (THRESHOLD)
  ) u_dec (
    .dout_a(dout_a),
    .bits  (dec_bits)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_SETUP;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_IDLE;
`ifdef SRAM_INIT_READBACK_EN
        // dout_a still carries the word read before the write took effect
        rsp_valid_d = 1'b1;
        rsp_data_d  = dec_bits;
`else
        // rsp_data only changes when a response is emitted, so writes leave it alone
        if (!we_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = dec_bits;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // rst gates ready directly so it drops in the same instant rst rises
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Address/data lanes come straight from the latched request, so they hold
  // their last value through IDLE and collapse to 0 under reset.
  assign clk_a = (state_q == ST_STROBE) ? FS_LV : '0;
  assign we_a  = (we_q && (state_q == ST_SETUP || state_q == ST_STROBE)) ? FS_LV : '0;

  always_comb begin
    for (int i = 0; i < ADDR_WIDTH; i++) addr_a[i] = addr_q[i] ? FS_LV : '0;
    for (int i = 0; i < DATA_WIDTH; i++) din_a[i] = wdata_q[i] ? FS_LV : '0;
  end

endmodule

// File: tb/tb_sram_ana_initiator.sv
// tb/tb_sram_ana_initiator.sv - randomized self-checking bench for sram_ana_initiator
module tb_sram_ana_initiator;
  import sram_ana_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int AWID = 8;
  localparam int FS   = 255;
  localparam int TH   = 128;
  localparam int NW   = 1 << AW;
`ifdef SRAM_INIT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [AWID-1:0] clk_a, we_a;
  logic [AWID-1:0] addr_a [AW];
  logic [AWID-1:0] din_a  [DW];
  logic [AWID-1:0] dout_a [DW];

  always #5 clk = ~clk;

  sram_ana_initiator #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ANA_WIDTH(AWID), .FULL_SCALE(FS), .THRESHOLD(TH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .clk_a(clk_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural SRAM on the analog side (environment)
  logic [DW-1:0]   sram_mem [NW];
  logic [DW-1:0]   dout_word = '0;
  int              pulses = 0;
  bit              ovr_en = 1'b0;
  logic [AWID-1:0] ovr_lv [DW];
  logic            sram_clk;

  // Reference model of what the initiator should return
  logic [DW-1:0]   ref_mem [NW];
  logic [DW-1:0]   last_rsp = '0;

  function automatic logic [AWID-1:0] lvl(input logic b);
    return b ? AWID'(FS) : '0;
  endfunction

  assign sram_clk = (clk_a >= AWID'(TH));

  always @(posedge sram_clk) begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    pulses++;
    for (int i = 0; i < AW; i++) a[i] = (addr_a[i] >= AWID'(TH));
    for (int i = 0; i < DW; i++) d[i] = (din_a[i] >= AWID'(TH));
    dout_word = sram_mem[a];
    if (we_a >= AWID'(TH)) sram_mem[a] = d;
  end

  always_comb begin
    for (int i = 0; i < DW; i++) dout_a[i] = ovr_en ? ovr_lv[i] : lvl(dout_word[i]);
  end

  // One full transaction with a per-cycle timeline check from the handshake edge on.
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [DW-1:0] exp_old);
    int wait_n = 0;
    int p0;
    bit exp_rsp;
    bit bad;
    logic [DW-1:0] hold, exp_d;
    logic [AWID-1:0] exp_clk, exp_we;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    while (!req_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL ready_timeout got req_ready=%0b exp 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    p0 = pulses;
    exp_rsp = !we || RB;
    hold = last_rsp;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      exp_clk = (k == 1) ? AWID'(FS) : '0;
      exp_we  = (we && k <= 1) ? AWID'(FS) : '0;
      exp_d   = (k >= 3 && exp_rsp) ? exp_old : hold;
      checks++;
      if (clk_a !== exp_clk) begin
        errors++; $display("FAIL clk_a k=%0d got %0d exp %0d", k, clk_a, exp_clk);
      end
      checks++;
      if (we_a !== exp_we) begin
        errors++; $display("FAIL we_a k=%0d got %0d exp %0d", k, we_a, exp_we);
      end
      checks++;
      if (rsp_valid !== (k == 3 && exp_rsp)) begin
        errors++; $display("FAIL rsp_valid k=%0d got %0b exp %0b", k, rsp_valid, (k == 3 && exp_rsp));
      end
      checks++;
      if (rsp_data !== exp_d) begin
        errors++; $display("FAIL rsp_data k=%0d got %0h exp %0h", k, rsp_data, exp_d);
      end
      bad = 1'b0;
      for (int i = 0; i < AW; i++) if (addr_a[i] !== lvl(addr[i])) bad = 1'b1;
      for (int i = 0; i < DW; i++) if (din_a[i] !== lvl(wd[i])) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++; $display("FAIL addr_din_lanes k=%0d got addr_a[0]=%0d din_a[0]=%0d exp addr %0h data %0h",
                           k, addr_a[0], din_a[0], addr, wd);
      end
    end
    if (exp_rsp) last_rsp = exp_old;
    if (we) ref_mem[addr] = wd;
    checks++;
    if (pulses - p0 !== 1) begin
      errors++; $display("FAIL strobe_count got %0d exp 1", pulses - p0);
    end
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    for (int i = 0; i < AW; i++) if (addr_a[i] !== '0) bad = 1'b1;
    for (int i = 0; i < DW; i++) if (din_a[i] !== '0) bad = 1'b1;
    checks++;
    if (bad || clk_a !== '0 || we_a !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got clk_a=%0d we_a=%0d rsp_valid=%0b rsp_data=%0h req_ready=%0b lanes_bad=%0b exp all 0",
               clk_a, we_a, rsp_valid, rsp_data, req_ready, bad);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset got %0b exp 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    txn(1'b1, 4'd2, 8'hA5, ref_mem[2]);
    txn(1'b0, 4'd2, 8'h00, ref_mem[2]);
    checks++;
    if (rsp_data !== 8'hA5) begin
      errors++; $display("FAIL read_a5 got %0h exp a5", rsp_data);
    end
    txn(1'b1, 4'd2, 8'h3C, ref_mem[2]);
    checks++;
    if (rsp_data !== (RB ? 8'hA5 : 8'hA5)) begin
      errors++; $display("FAIL after_write_3c got %0h exp a5", rsp_data);
    end
    txn(1'b0, 4'd2, 8'h00, ref_mem[2]);
    checks++;
    if (rsp_data !== 8'h3C) begin
      errors++; $display("FAIL read_3c got %0h exp 3c", rsp_data);
    end
  endtask

  task automatic test_lane_decode();
    logic [DW-1:0] exp;
    ovr_lv[0] = 8'd127; ovr_lv[1] = 8'd128; ovr_lv[2] = 8'd200; ovr_lv[3] = 8'd0;
    for (int i = 4; i < DW; i++) ovr_lv[i] = AWID'($urandom_range(0, 255));
    for (int i = 0; i < DW; i++) exp[i] = (int'(ovr_lv[i]) >= TH);
    ovr_en = 1'b1;
    txn(1'b0, AW'($urandom_range(0, NW - 1)), 8'h00, exp);
    ovr_en = 1'b0;
    checks++;
    if (rsp_data[3:0] !== 4'b0110) begin
      errors++; $display("FAIL lane_decode_low got %0b exp 0110", rsp_data[3:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] al [3];
    int n = 0;
    bit exp_rv;
    al[0] = 4'd0; al[1] = 4'd1; al[2] = 4'd15;
    @(negedge clk);
    for (int c = 0; c <= 12; c++) begin
      req_valid = (n < 3);
      req_we    = 1'b0;
      if (n < 3) req_addr = al[n];
      checks++;
      if (req_ready !== (c % 4 == 0)) begin
        errors++; $display("FAIL b2b_ready c=%0d got %0b exp %0b", c, req_ready, (c % 4 == 0));
      end
      exp_rv = (c == 4 || c == 8 || c == 12);
      checks++;
      if (rsp_valid !== exp_rv) begin
        errors++; $display("FAIL b2b_rsp_valid c=%0d got %0b exp %0b", c, rsp_valid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (rsp_data !== ref_mem[al[c/4-1]]) begin
          errors++; $display("FAIL b2b_rsp_data c=%0d got %0h exp %0h", c, rsp_data, ref_mem[al[c/4-1]]);
        end
      end
      if (req_valid && req_ready) n++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    last_rsp = ref_mem[al[2]];
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL b2b_count got %0d exp 3", n);
    end
  endtask

  task automatic test_reset_abort();
    logic [AW-1:0] a = AW'($urandom_range(0, NW - 1));
    logic [AW-1:0] b = AW'($urandom_range(0, NW - 1));
    bit bad = 1'b0;
    int p0;
    // Read aborted in STROBE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < AW; i++) if (addr_a[i] !== '0) bad = 1'b1;
    for (int i = 0; i < DW; i++) if (din_a[i] !== '0) bad = 1'b1;
    checks++;
    if (bad || clk_a !== '0 || we_a !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs got clk_a=%0d we_a=%0d rsp_valid=%0b rsp_data=%0h req_ready=%0b lanes_bad=%0b exp all 0",
               clk_a, we_a, rsp_valid, rsp_data, req_ready, bad);
    end
    last_rsp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL abort_no_rsp c=%0d got %0b exp 0", c, rsp_valid);
      end
    end
    // Write aborted in SETUP must never reach the SRAM
    p0 = pulses;
    req_valid = 1'b1; req_we = 1'b1; req_addr = b; req_wdata = ~ref_mem[b];
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pulses - p0 !== 0) begin
      errors++; $display("FAIL abort_setup_strobe got %0d pulses exp 0", pulses - p0);
    end
    txn(1'b0, a, 8'h00, ref_mem[a]);
    txn(1'b0, b, 8'h00, ref_mem[b]);
  endtask

  task automatic test_random();
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int t = 0; t < 24; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, NW - 1));
      d  = DW'($urandom_range(0, 255));
      txn(we, a, d, ref_mem[a]);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < NW; i++) begin
      v = DW'($urandom_range(0, 255));
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    for (int i = 0; i < DW; i++) ovr_lv[i] = '0;
    test_reset();
    test_write_read();
    test_lane_decode();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
